// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the MEM-stage to 16-bit asynchronous SRAM bridge.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_AW       = 18;
  localparam int unsigned SRAM_DW       = 16;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned DEF_BASE_ADDR = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_H0,
    S_H1,
    S_WAIT,
    S_DONE
  } state_e;

endpackage

// File: rtl/sram_controller_if.sv
// Word-level request/response bundle between the MEM stage and the SRAM bridge.
interface sram_controller_if;
  import sram_ctrl_pkg::*;

  logic [WORD_W-1:0] adr;
  logic [WORD_W-1:0] data_in;
  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic [WORD_W-1:0] DATA;
  logic              ready;

  modport master (output adr, data_in, MEM_R_EN, MEM_W_EN, input DATA, ready);
  modport slave  (input adr, data_in, MEM_R_EN, MEM_W_EN, output DATA, ready);
endinterface

// File: rtl/sram_controller_dq_buf.sv
// Tri-state driver for the bidirectional SRAM data bus.
module sram_dq_buf
  import sram_ctrl_pkg::*;
(
  input  logic               oe,
  input  logic [SRAM_DW-1:0] dout,
  output logic [SRAM_DW-1:0] din,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ
);

  assign SRAM_DQ = oe ? dout : {SRAM_DW{1'bz}};
  assign din     = SRAM_DQ;

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage access into two big-endian halfword SRAM cycles,
// padded to a fixed ACCESS_CYCLES latency; ready holds the pipeline meanwhile.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 6,
  parameter int unsigned BASE_ADDR     = DEF_BASE_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   mem,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N
);

  localparam int unsigned CW = $clog2(ACCESS_CYCLES + 1);
  localparam int unsigned HW = SRAM_AW - 1;

  state_e              r_state, w_next;
  logic [CW-1:0]       r_cnt, w_cnt_next;
  logic                r_is_wr;
  logic [HW-1:0]       r_base;
  logic [WORD_W-1:0]   r_wdata;
  logic [WORD_W-1:0]   r_data;
  logic                w_req;
  logic                w_half;
  logic                w_oe;
  logic [HW-1:0]       w_base;
  logic [SRAM_DW-1:0]  w_dout;
  logic [SRAM_DW-1:0]  w_din;

  assign w_req  = mem.MEM_R_EN | mem.MEM_W_EN;
  // Word index within the SRAM window; the cast drops upper bits so addresses wrap.
  assign w_base = HW'((mem.adr - WORD_W'(BASE_ADDR)) >> 2);

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: if (w_req) w_next = S_H0;
      S_H0:   w_next = S_H1;
      S_H1: begin
        if (ACCESS_CYCLES > 4) begin
          w_next     = S_WAIT;
          w_cnt_next = CW'(ACCESS_CYCLES - 4);
        end else begin
          w_next = S_DONE;
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_is_wr <= 1'b0;
      r_base  <= '0;
      r_wdata <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (r_state == S_IDLE && w_req) begin
        r_is_wr <= ~mem.MEM_R_EN;
        r_base  <= w_base;
        r_wdata <= mem.data_in;
      end
      if (!r_is_wr && r_state == S_H0) r_data[31:16] <= w_din;
      if (!r_is_wr && r_state == S_H1) r_data[15:0]  <= w_din;
    end
  end

  assign w_half    = (r_state == S_H1);
  assign w_oe      = r_is_wr & ((r_state == S_H0) | (r_state == S_H1));
  assign w_dout    = w_half ? r_wdata[15:0] : r_wdata[31:16];
  assign SRAM_ADDR = {r_base, w_half};
  assign SRAM_WE_N = ~w_oe;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  assign mem.ready = rst | (r_state == S_DONE) | ((r_state == S_IDLE) & ~w_req);
  assign mem.DATA  = r_data;

  sram_dq_buf u_dq_buf (
    .oe      (w_oe),
    .dout    (w_dout),
    .din     (w_din),
    .SRAM_DQ (SRAM_DQ)
  );

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboarded bench: two controllers (6- and 4-cycle access) against word-level reference models.
module tb_sram_controller;

  localparam int unsigned BASE   = 1024;
  localparam int unsigned NWORDS = 131072;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    bit          b2b;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [16:0] widx(input logic [31:0] a);
    return 17'((a - BASE) >> 2);
  endfunction

  function automatic logic [15:0] pat4(input int unsigned i);
    return 16'((i * 7) ^ 32'h3c3c);
  endfunction

  // ---------------- DUT with ACCESS_CYCLES = 6 ----------------
  sram_controller_if bus6();
  wire  [15:0] dq6;
  logic [17:0] addr6;
  logic        we6_n, ub6_n, lb6_n, ce6_n, oe6_n;

  sram_controller #(.ACCESS_CYCLES(6), .BASE_ADDR(BASE)) u6 (
    .clk(clk), .rst(rst), .mem(bus6), .SRAM_DQ(dq6), .SRAM_ADDR(addr6),
    .SRAM_WE_N(we6_n), .SRAM_UB_N(ub6_n), .SRAM_LB_N(lb6_n), .SRAM_CE_N(ce6_n), .SRAM_OE_N(oe6_n)
  );

  logic [15:0] sram6 [262144];
  logic [31:0] ref6  [NWORDS];
  assign dq6 = we6_n ? sram6[addr6] : 16'hzzzz;
  always @(posedge clk) if (!we6_n) sram6[addr6] = dq6;

  // ---------------- DUT with ACCESS_CYCLES = 4 ----------------
  sram_controller_if bus4();
  wire  [15:0] dq4;
  logic [17:0] addr4;
  logic        we4_n, ub4_n, lb4_n, ce4_n, oe4_n;

  sram_controller #(.ACCESS_CYCLES(4), .BASE_ADDR(BASE)) u4 (
    .clk(clk), .rst(rst), .mem(bus4), .SRAM_DQ(dq4), .SRAM_ADDR(addr4),
    .SRAM_WE_N(we4_n), .SRAM_UB_N(ub4_n), .SRAM_LB_N(lb4_n), .SRAM_CE_N(ce4_n), .SRAM_OE_N(oe4_n)
  );

  logic [15:0] sram4 [262144];
  assign dq4 = we4_n ? sram4[addr4] : 16'hzzzz;
  always @(posedge clk) if (!we4_n) sram4[addr4] = dq4;

  exp_t q6[$];
  exp_t q4[$];

  // ---------------- monitors ----------------
  bit          busy6 = 0, busy4 = 0;
  int unsigned st6, st4, last6, last4;
  logic [7:0]  mask6, mask4;

  initial begin : mon6
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) busy6 = 0;
      else if (bus6.MEM_R_EN | bus6.MEM_W_EN) begin
        if (!busy6) begin busy6 = 1; st6 = cyc; mask6 = '0; end
        if (!we6_n && (cyc - st6) < 8) mask6[cyc - st6] = 1'b1;
        if (bus6.ready) begin
          busy6 = 0;
          chk("q6_pending", 32'(q6.size() > 0), 1);
          if (q6.size() > 0) begin
            e = q6.pop_front();
            chk("latency6", cyc - st6, 5);
            chk("we_n_window6", 32'(mask6), e.rd ? 32'h0 : 32'h6);
            if (e.rd) chk("data6", bus6.DATA, e.data);
            if (e.b2b) chk("period6", cyc - last6, 6);
          end
          last6 = cyc;
        end
      end
    end
  end

  initial begin : mon4
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) busy4 = 0;
      else if (bus4.MEM_R_EN | bus4.MEM_W_EN) begin
        if (!busy4) begin busy4 = 1; st4 = cyc; mask4 = '0; end
        if (!we4_n && (cyc - st4) < 8) mask4[cyc - st4] = 1'b1;
        if (bus4.ready) begin
          busy4 = 0;
          chk("q4_pending", 32'(q4.size() > 0), 1);
          if (q4.size() > 0) begin
            e = q4.pop_front();
            chk("latency4", cyc - st4, 3);
            chk("we_n_window4", 32'(mask4), 32'h0);
            chk("data4", bus4.DATA, e.data);
            if (e.b2b) chk("period4", cyc - last4, 4);
          end
          last4 = cyc;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic issue6(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d, input bit b2b);
    exp_t e;
    int unsigned n;
    e.rd   = rd;
    e.b2b  = b2b;
    e.data = ref6[widx(a)];
    if (!rd && wr) ref6[widx(a)] = d;
    q6.push_back(e);
    bus6.adr = a; bus6.data_in = d; bus6.MEM_R_EN = rd; bus6.MEM_W_EN = wr;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus6.ready && n < 50);
    if (!bus6.ready) chk("ready_timeout6", 32'(bus6.ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic issue4(input logic [31:0] a, input bit b2b);
    exp_t e;
    int unsigned n;
    logic [16:0] w;
    w      = widx(a);
    e.rd   = 1;
    e.b2b  = b2b;
    e.data = {pat4({w, 1'b0}), pat4({w, 1'b1})};
    q4.push_back(e);
    bus4.adr = a; bus4.data_in = $urandom; bus4.MEM_R_EN = 1; bus4.MEM_W_EN = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus4.ready && n < 50);
    if (!bus4.ready) chk("ready_timeout4", 32'(bus4.ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic idle6(input int unsigned n);
    bus6.MEM_R_EN = 0; bus6.MEM_W_EN = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] a;
    int unsigned gap;
    int unsigned op;
    rst = 1'b1;
    bus6.adr = '0; bus6.data_in = '0; bus6.MEM_R_EN = 0; bus6.MEM_W_EN = 0;
    bus4.adr = '0; bus4.data_in = '0; bus4.MEM_R_EN = 0; bus4.MEM_W_EN = 0;
    for (int unsigned i = 0; i < NWORDS; i++) begin
      ref6[i] = $urandom;
      sram6[2*i]   = ref6[i][31:16];
      sram6[2*i+1] = ref6[i][15:0];
      sram4[2*i]   = pat4(2*i);
      sram4[2*i+1] = pat4(2*i+1);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus6.ready), 1);
    chk("rst_we_n", 32'(we6_n), 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(bus6.ready), 1);
    chk("idle_data", bus6.DATA, 0);
    chk("idle_addr", 32'(addr6), 0);
    chk("idle_we_n", 32'(we6_n), 1);
    @(posedge clk); #1;

    issue6(0, 1, 1024, 32'hDEADBEEF, 0);
    idle6(1);
    chk("hw0_after_write", 32'(sram6[0]), 32'hDEAD);
    chk("hw1_after_write", 32'(sram6[1]), 32'hBEEF);
    issue6(1, 0, 1024, 32'h0, 0);
    idle6(1);

    issue6(0, 1, 1031, 32'h12345678, 0);
    idle6(1);
    chk("hw2_after_write", 32'(sram6[2]), 32'h1234);
    chk("hw3_after_write", 32'(sram6[3]), 32'h5678);
    issue6(1, 0, 1028, 32'h0, 0);
    idle6(2);

    issue6(1, 1, 1024, 32'h0, 0);
    idle6(1);
    chk("both_hw0_kept", 32'(sram6[0]), 32'hDEAD);
    chk("both_hw1_kept", 32'(sram6[1]), 32'hBEEF);

    // write to word 1000, aborted by reset during its second halfword
    bus6.adr = BASE + 4000; bus6.data_in = 32'hCAFEF00D; bus6.MEM_W_EN = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; bus6.MEM_W_EN = 0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_we_n", 32'(we6_n), 1);
    chk("abort_ready", 32'(bus6.ready), 1);
    chk("abort_addr", 32'(addr6), 0);
    @(posedge clk); #1;
    issue6(1, 0, BASE + 4004, 32'h0, 0);
    idle6(1);

    for (int unsigned k = 0; k < 40; k++) begin
      op = $urandom_range(0, 2);
      a  = BASE + 4 * $urandom_range(0, 63) + $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: a = a + 32'h0008_0000;
        1: a = 4 * $urandom_range(0, 3) + $urandom_range(0, 3);
        default: ;
      endcase
      gap = $urandom_range(0, 2);
      if (gap != 0) idle6(gap);
      issue6(op != 1, op != 0, a, $urandom, gap == 0 && k != 0);
    end
    idle6(1);

    for (int unsigned k = 0; k < 8; k++)
      issue6(1, 0, BASE + 4 * $urandom_range(0, 63), 32'h0, k != 0);
    idle6(2);

    for (int unsigned k = 0; k < 8; k++)
      issue4(BASE + 4 * $urandom_range(0, 511) + $urandom_range(0, 3), k != 0);
    bus4.MEM_R_EN = 0;
    repeat (3) @(posedge clk);
    #1;

    chk("q6_drained", q6.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle bridge between the MEM stage and an external 16-bit asynchronous SRAM, replacing the on-chip byte-array data memory when the design targets the board SRAM. It takes the same word-level read/write request the MEM stage already produces (byte address, 32-bit write data, read/write enables), splits each word into two halfword SRAM cycles, and returns the read word. A `ready` output holds the pipeline frozen until the access completes.

## Interface
- `ACCESS_CYCLES`, 6: cycles from request acceptance to the `ready` pulse; legal range ≥ 4.
- `BASE_ADDR`, 1024: byte address mapped to SRAM halfword 0.
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `adr` in 32: byte address from the MEM stage.
- `data_in` in 32: store data.
- `MEM_R_EN` in 1: read request; held stable by the pipeline while `ready` = 0.
- `MEM_W_EN` in 1: write request; same rule.
- `DATA` out 32: registered read word.
- `ready` out 1: 0 freezes the pipeline; 1-cycle high pulse at access completion.
- `SRAM_DQ` inout 16: SRAM data bus, high-Z unless writing.
- `SRAM_ADDR` out 18: SRAM halfword address.
- `SRAM_WE_N` out 1: write strobe, active-low.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N` out 1 each: tied 0 (always enabled).

## Operation
- States: IDLE, H0, H1, WAIT, DONE.
- IDLE: if `MEM_R_EN | MEM_W_EN`, latch op, `adr`, `data_in`; go to H0. Read wins when both are asserted; no write strobe is issued.
- Word base = `adr - BASE_ADDR` with bits [1:0] forced to 0. Halfword addresses = {base[18:2], 1'b0} and {base[18:2], 1'b1}. Upper bits are truncated, so addresses wrap modulo 512 KiB.
- Big-endian halves: the even halfword holds word[31:16]; the odd halfword holds word[15:0].
- H0: drive the even address. On write: `SRAM_WE_N` = 0 and DQ = data[31:16]. On read: DQ is high-Z; sample into DATA[31:16] at the end of the cycle.
- H1: same as H0 for the odd address and [15:0]. Then go to WAIT.
- WAIT: a down-counter spends ACCESS_CYCLES−4 cycles here (0 cycles allowed, which skips straight to DONE). `SRAM_WE_N` = 1, DQ high-Z.
- DONE: `ready` = 1; go to IDLE unconditionally.
- `ready` is combinational: 1 in IDLE with no request, 1 in DONE, 1 while `rst`; 0 otherwise.
- `DATA` updates only on reads and holds its value across writes and idle cycles.

## Timing
- Request first visible in IDLE = cycle 0. `ready` is 0 in cycles 0 through ACCESS_CYCLES−2 and 1 in cycle ACCESS_CYCLES−1. The pipeline advances on the edge that ends DONE.
- Read data is valid on `DATA` from DONE onward.
- Back-to-back requests: the IDLE cycle after DONE accepts the next request. Period is ACCESS_CYCLES+... more precisely, one access every ACCESS_CYCLES cycles.
- Reset values: state IDLE, `DATA` = 0, `SRAM_WE_N` = 1, DQ high-Z, `SRAM_ADDR` = 0, counter = 0, `ready` = 1.
- Reset mid-access, including during a write H0/H1: abort at the next edge. WE_N goes high and DQ is released; the SRAM half-word contents are undefined. No `ready` pulse is issued.
- Request dropped mid-access (protocol violation): the access still completes on latched values.

## Structure
- Package `sram_ctrl_pkg`: state enum, `SRAM_AW` = 18, `SRAM_DW` = 16, default `BASE_ADDR`.
- One sub-module: `sram_dq_buf`, the tri-state driver (`oe`, `dout`, `din`, `SRAM_DQ`). The FSM, counter and address computation stay in the top level.

## Test plan
- Write 0xDEADBEEF at `adr` 1024 → SRAM halfword 0 = 0xDEAD, halfword 1 = 0xBEEF. WE_N low exactly in cycles 1–2. `ready` = 1 only in cycle 5.
- Read `adr` 1024 after that write → `DATA` = 0xDEADBEEF in cycle 5. WE_N stays high throughout; DQ is never driven by the controller.
- Unaligned `adr` 1031 with write 0x12345678 → halfwords 2/3 = 0x1234/0x5678. A read of 1028 returns 0x12345678.
- `MEM_R_EN` = `MEM_W_EN` = 1 at `adr` 1024 with `data_in` 0 → read performed, `DATA` = 0xDEADBEEF, memory unchanged.
- `rst` asserted during H1 of a write → next cycle: state IDLE, WE_N = 1, DQ = Z, `ready` = 1. The following read of an untouched word returns that word's prior value.
- Continuous read stream, with ACCESS_CYCLES = 6 and again with 4 → `ready` pulses exactly every 6 (resp. 4) cycles. With 4, WAIT is never entered.
